// File: rtl/alu_muldiv_param_if.sv
// Handshake and data bundle between the execute-stage controller and alu_muldiv_param.
// Carries no logic, so it adds no latency of its own.
// The master drives the operands and in_valid and must hold them until in_ready is high.
// Ports:
//   master: drives Signal/dataA/dataB/in_valid; observes in_ready, Output, out_valid, busy, done
//   slave : the reverse view, used by the ALU
interface alu_muldiv_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Output;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output dataA, dataB, Signal, in_valid,
        input  in_ready, Output, out_valid, busy, done
    );

    modport slave (
        input  dataA, dataB, Signal, in_valid,
        output in_ready, Output, out_valid, busy, done
    );
endinterface

// File: rtl/alu_muldiv_param.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO, iterative MULTU (and DIVU) into HI/LO.
// Latency: single-cycle ops are registered 1 cycle; MULTU/DIVU hold busy for WIDTH+1 cycles, then pulse done.
// Backpressure: in_ready = !busy; a held in_valid is accepted only in the first cycle with in_ready high.
// Ports: clk, reset (sync, active-low), bus (alu_muldiv_param_if.slave).
// Optional feature: define ALU_DIVU_EN to build the restoring divider (opcode 27, DIV state).
module alu_muldiv_param #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    alu_muldiv_param_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MULTU = 6'd25;
`ifdef ALU_DIVU_EN
    localparam logic [5:0] OP_DIVU  = 6'd27;
`endif
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
`ifdef ALU_DIVU_EN
        DIV,
`endif
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // Shared working pair: product {hi,lo} for MULTU, {remainder,quotient} for DIVU.
    logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d;
    logic [WIDTH-1:0] wrk_lo_q, wrk_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIVU_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
`endif

    // Single-cycle result; unknown opcodes (and DIVU when not built) read as zero.
    always_comb begin
        alu_res = '0;
        case (bus.Signal)
            OP_AND:  alu_res = bus.dataA & bus.dataB;
            OP_OR:   alu_res = bus.dataA | bus.dataB;
            OP_ADD:  alu_res = bus.dataA + bus.dataB;
            OP_SUB:  alu_res = bus.dataA - bus.dataB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
            OP_SRL:  alu_res = bus.dataA >> bus.dataB[SHW-1:0];
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wrk_hi_d  = wrk_hi_q;
        wrk_lo_d  = wrk_lo_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        done_d    = 1'b0;
        accept    = bus.in_valid && (state_q == IDLE);

        // Shift-add step: add multiplicand when the multiplier LSB is set, then shift {carry,hi,lo} right.
        mul_sum   = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, opb_q} : '0);
`ifdef ALU_DIVU_EN
        // Restoring step: bring the next dividend bit into the remainder, subtract if it fits.
        // With a zero divisor every step "fits", giving quotient all ones and remainder = dividend.
        div_shift = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift - {1'b0, opb_q};
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.Signal == OP_MULTU) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        wrk_hi_d = '0;
                        wrk_lo_d = bus.dataA;
                        opb_d    = bus.dataB;
`ifdef ALU_DIVU_EN
                    end else if (bus.Signal == OP_DIVU) begin
                        state_d  = DIV;
                        cnt_d    = '0;
                        wrk_hi_d = '0;
                        wrk_lo_d = bus.dataA;
                        opb_d    = bus.dataB;
`endif
                    end else begin
                        out_d     = alu_res;
                        out_vld_d = 1'b1;
                    end
                end
            end
            MUL: begin
                {wrk_hi_d, wrk_lo_d} = {mul_sum, wrk_lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) state_d = FIN;
            end
`ifdef ALU_DIVU_EN
            DIV: begin
                wrk_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                wrk_lo_d = {wrk_lo_q[WIDTH-2:0], div_ge};
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) state_d = FIN;
            end
`endif
            FIN: begin
                hi_d    = wrk_hi_q;
                lo_d    = wrk_lo_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wrk_hi_q  <= '0;
            wrk_lo_q  <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wrk_hi_q  <= wrk_hi_d;
            wrk_lo_q  <= wrk_lo_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.Output    = out_q;
    assign bus.out_valid = out_vld_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_muldiv_param.sv
module tb_alu_muldiv_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_muldiv_param_if #(.WIDTH(32)) a_if ();
    alu_muldiv_param_if #(.WIDTH(8))  b_if ();

    alu_muldiv_param #(.WIDTH(32)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    alu_muldiv_param #(.WIDTH(8))  u_b (.clk(clk), .reset(reset), .bus(b_if));

    int tests    = 0;
    int failures = 0;

    // Reference architectural state for the 32-bit instance.
    logic [31:0] m_hi, m_lo, m_out;

    logic [5:0] ops [10] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18, 6'd63, 6'd0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_single(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd2:    return a >> (b % 32);
            6'd16:   return m_hi;
            6'd18:   return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Present one single-cycle op at the next edge and check the registered result.
    task automatic do_single(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        exp = model_single(op, a, b);
        a_if.Signal   = op;
        a_if.dataA    = a;
        a_if.dataB    = b;
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        m_out = exp;
        check({tag, " out"}, a_if.Output, exp);
        check({tag, " vld"}, a_if.out_valid, 1);
    endtask

    // Run MULTU/DIVU to completion; returns in the done cycle, #1 after the edge.
    task automatic do_multi(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic saw_done;
        logic [63:0] prod;
        a_if.Signal   = op;
        a_if.dataA    = a;
        a_if.dataB    = b;
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        a_if.dataA    = ~a;
        a_if.dataB    = ~b;
        check({tag, " rdy0"}, a_if.in_ready, 0);
        n = 0;
        saw_done = 1'b0;
        while (a_if.busy && n < 100) begin
            n++;
            saw_done |= a_if.done;
            if (a_if.out_valid) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check({tag, " busy cycles"}, n, 33);
        check({tag, " early done/vld"}, saw_done, 0);
        check({tag, " done"}, a_if.done, 1);
        check({tag, " rdy1"}, a_if.in_ready, 1);
        check({tag, " out kept"}, a_if.Output, m_out);
        if (op == 6'd25) begin
            prod = {32'd0, a} * {32'd0, b};
            m_hi = prod[63:32];
            m_lo = prod[31:0];
        end else if (b == 32'd0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
    endtask

    initial begin
        int n;
        logic saw;
        logic [5:0] op;
        logic [31:0] ra, rb;

        reset = 1'b0;
        a_if.Signal = '0; a_if.dataA = '0; a_if.dataB = '0; a_if.in_valid = 1'b0;
        b_if.Signal = '0; b_if.dataA = '0; b_if.dataB = '0; b_if.in_valid = 1'b0;
        m_hi = '0; m_lo = '0; m_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out", a_if.Output, 0);
        check("rst vld", a_if.out_valid, 0);
        check("rst busy", a_if.busy, 0);
        check("rst done", a_if.done, 0);
        check("rst rdy", a_if.in_ready, 1);
        reset = 1'b1;
        do_single("rst hi", 6'd16, 0, 0);
        do_single("rst lo", 6'd18, 0, 0);

        // Directed single-cycle ops, issued back to back.
        do_single("add 7+5", 6'd32, 32'd7, 32'd5);
        check("add value", a_if.Output, 32'd12);
        do_single("sub 5-7", 6'd34, 32'd5, 32'd7);
        check("sub value", a_if.Output, 32'hFFFF_FFFE);
        do_single("slt -1<1", 6'd42, 32'hFFFF_FFFF, 32'd1);
        do_single("slt 1<-1", 6'd42, 32'd1, 32'hFFFF_FFFF);
        do_single("srl 33", 6'd2, 32'h8000_0000, 32'd33);
        check("srl value", a_if.Output, 32'h4000_0000);
        do_single("and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00);
        do_single("or", 6'd37, 32'hF0F0_1234, 32'h0FF0_FF00);
        do_single("undef 63", 6'd63, 32'h1234, 32'h5678);
        @(posedge clk); #1;
        check("vld drops", a_if.out_valid, 0);
        check("out holds", a_if.Output, m_out);

        // Full-width product; MFHI accepted in the done cycle sees the new HI.
        do_multi("multu max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_single("mfhi max", 6'd16, 0, 0);
        check("mfhi value", a_if.Output, 32'hFFFF_FFFE);
        check("done pulse", a_if.done, 0);
        do_single("mflo max", 6'd18, 0, 0);
        check("mflo value", a_if.Output, 32'h0000_0001);

        // ADD held while busy is only taken once in_ready returns.
        a_if.Signal = 6'd25; a_if.dataA = 32'd5; a_if.dataB = 32'd6; a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.Signal = 6'd32; a_if.dataA = 32'd1; a_if.dataB = 32'd2;
        n = 0; saw = 1'b0;
        while (a_if.busy && n < 100) begin
            n++;
            saw |= a_if.out_valid;
            @(posedge clk); #1;
        end
        check("hold busy cycles", n, 33);
        check("hold no early accept", saw, 0);
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        check("held add out", a_if.Output, 32'd3);
        check("held add vld", a_if.out_valid, 1);
        m_hi = 32'd0; m_lo = 32'd30; m_out = 32'd3;
        do_single("mflo 5x6", 6'd18, 0, 0);

`ifdef ALU_DIVU_EN
        do_multi("divu 100/7", 6'd27, 32'd100, 32'd7);
        do_single("divu lo", 6'd18, 0, 0);
        check("divu q", a_if.Output, 32'd14);
        do_single("divu hi", 6'd16, 0, 0);
        check("divu r", a_if.Output, 32'd2);
        do_multi("divu 9/0", 6'd27, 32'd9, 32'd0);
        do_single("div0 lo", 6'd18, 0, 0);
        check("div0 q", a_if.Output, 32'hFFFF_FFFF);
        do_single("div0 hi", 6'd16, 0, 0);
        check("div0 r", a_if.Output, 32'd9);
`else
        do_single("divu off", 6'd27, 32'd100, 32'd7);
        check("divu off busy", a_if.busy, 0);
        do_single("divu off lo", 6'd18, 0, 0);
        check("divu off lo keep", a_if.Output, 32'd30);
`endif

        // Randomized single-cycle ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_single("rand op", op, ra, rb);
        end

        // Randomized multicycle ops.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_multi("rand multu", 6'd25, ra, rb);
            do_single("rand mfhi", 6'd16, 0, 0);
            do_single("rand mflo", 6'd18, 0, 0);
`ifdef ALU_DIVU_EN
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom >> $urandom_range(0, 31);
            do_multi("rand divu", 6'd27, ra, rb);
            do_single("rand dhi", 6'd16, 0, 0);
            do_single("rand dlo", 6'd18, 0, 0);
`endif
        end

        // Reset at the 10th busy cycle abandons the multiply.
        a_if.Signal = 6'd25; a_if.dataA = 32'd3; a_if.dataB = 32'd4; a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid busy", a_if.busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("mid rst busy", a_if.busy, 0);
        check("mid rst done", a_if.done, 0);
        check("mid rst out", a_if.Output, 0);
        m_hi = '0; m_lo = '0; m_out = '0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw |= a_if.done;
        end
        check("mid rst no done", saw, 0);
        do_single("mid rst mflo", 6'd18, 0, 0);
        do_single("mid rst mfhi", 6'd16, 0, 0);

        // WIDTH = 8 instance.
        b_if.Signal = 6'd25; b_if.dataA = 8'hFF; b_if.dataB = 8'h02; b_if.in_valid = 1'b1;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        n = 0;
        while (b_if.busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("w8 busy cycles", n, 9);
        check("w8 done", b_if.done, 1);
        b_if.Signal = 6'd16; b_if.in_valid = 1'b1;
        @(posedge clk); #1;
        check("w8 mfhi", b_if.Output, 8'h01);
        b_if.Signal = 6'd18;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        check("w8 mflo", b_if.Output, 8'hFE);
        b_if.Signal = 6'd2; b_if.dataA = 8'h80; b_if.dataB = 8'd11; b_if.in_valid = 1'b1;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        check("w8 srl", b_if.Output, 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
